// File: rtl/crop_stream_ctrl.sv
// crop_stream_ctrl: runs one myproject inference per frame. It forwards only the crop window
// of the incoming pixel stream to the core, drives ap_start/ap_done, and latches the first beat
// of every core output channel into a held result.
// Optional latency counter: define CROP_STREAM_CTRL_PERF_EN.
module crop_stream_ctrl #(
    parameter int unsigned FP_TOTAL = 16,
    parameter int unsigned IN_ROWS  = 100,
    parameter int unsigned IN_COLS  = 160,
    parameter int unsigned OUT_ROWS = 48,
    parameter int unsigned OUT_COLS = 48,
    parameter int unsigned NUM_OUT  = 5,
    parameter int unsigned Y_W      = $clog2(IN_ROWS),
    parameter int unsigned X_W      = $clog2(IN_COLS)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        cfg_start,
    input  logic [Y_W-1:0]              cfg_y1,
    input  logic [X_W-1:0]              cfg_x1,
    output logic                        cfg_err,
    output logic                        busy,
    input  logic [FP_TOTAL-1:0]         pix_TDATA,
    input  logic                        pix_TVALID,
    output logic                        pix_TREADY,
    output logic [FP_TOTAL-1:0]         core_in_TDATA,
    output logic                        core_in_TVALID,
    input  logic                        core_in_TREADY,
    output logic                        core_ap_start,
    input  logic                        core_ap_ready,
    input  logic                        core_ap_done,
    input  logic [NUM_OUT*FP_TOTAL-1:0] core_out_TDATA,
    input  logic [NUM_OUT-1:0]          core_out_TVALID,
    output logic [NUM_OUT-1:0]          core_out_TREADY,
    output logic [NUM_OUT*FP_TOTAL-1:0] result_data,
    output logic                        result_valid,
    input  logic                        result_ack,
    output logic [31:0]                 perf_cycles
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StResult} state_e;

    state_e                      state_q, state_d;
    logic [Y_W-1:0]              row_q, y1_q;
    logic [X_W-1:0]              col_q, x1_q;
    logic [NUM_OUT-1:0]          captured_q;
    logic                        done_seen_q;
    logic [NUM_OUT*FP_TOTAL-1:0] result_q;
    logic                        ap_start_q;
    logic                        cfg_err_q;

    logic               cfg_ok, start_acc, in_stream, active, in_win;
    logic               pix_hs, last_col, last_row, last_pix;
    logic [NUM_OUT-1:0] out_hs, captured_nx;
    logic               done_nx;

    // Window test, handshakes and same-cycle flag updates.
    always_comb begin
        cfg_ok    = (32'(cfg_y1) + OUT_ROWS <= IN_ROWS) && (32'(cfg_x1) + OUT_COLS <= IN_COLS);
        start_acc = (state_q == StIdle) && cfg_start && cfg_ok;
        in_stream = (state_q == StStream);
        active    = in_stream || (state_q == StDrain);
        in_win    = (32'(row_q) >= 32'(y1_q)) && (32'(row_q) < 32'(y1_q) + OUT_ROWS) &&
                    (32'(col_q) >= 32'(x1_q)) && (32'(col_q) < 32'(x1_q) + OUT_COLS);
        pix_TREADY     = in_stream && (in_win ? core_in_TREADY : 1'b1);
        core_in_TDATA  = pix_TDATA;
        core_in_TVALID = in_stream && pix_TVALID && in_win;
        pix_hs   = pix_TVALID && pix_TREADY;
        last_col = (col_q == X_W'(IN_COLS - 1));
        last_row = (row_q == Y_W'(IN_ROWS - 1));
        last_pix = pix_hs && last_col && last_row;
        core_out_TREADY = {NUM_OUT{active}} & ~captured_q;
        out_hs      = core_out_TVALID & core_out_TREADY;
        captured_nx = captured_q | out_hs;
        done_nx     = done_seen_q || (core_ap_done && active);
        busy          = (state_q != StIdle);
        result_valid  = (state_q == StResult);
        result_data   = result_q;
        core_ap_start = ap_start_q;
        cfg_err       = cfg_err_q;
    end

    // Next-state logic; DRAIN exit sees captures and done arriving this cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_acc) state_d = StStream;
            StStream: if (last_pix) state_d = StDrain;
            StDrain:  if ((&captured_nx) && done_nx) state_d = StResult;
            StResult: if (result_ack) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, origin latch, start handshake and config error pulse.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            y1_q       <= '0;
            x1_q       <= '0;
            ap_start_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == StIdle) && cfg_start && !cfg_ok;
            if (start_acc) begin
                y1_q       <= cfg_y1;
                x1_q       <= cfg_x1;
                ap_start_q <= 1'b1;
            end else if (ap_start_q && core_ap_ready) begin
                ap_start_q <= 1'b0;
            end
        end
    end

    // Raster position of the next input pixel; wraps to 0,0 after the last pixel.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (pix_hs) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Output capture: first beat per channel only, flags cleared when the result is taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            captured_q  <= '0;
            done_seen_q <= 1'b0;
            result_q    <= '0;
        end else begin
            if ((state_q == StResult) && result_ack) begin
                captured_q  <= '0;
                done_seen_q <= 1'b0;
            end else if (active) begin
                captured_q  <= captured_nx;
                done_seen_q <= done_nx;
            end
            for (int k = 0; k < int'(NUM_OUT); k++) begin
                if (out_hs[k]) result_q[k*FP_TOTAL +: FP_TOTAL] <= core_out_TDATA[k*FP_TOTAL +: FP_TOTAL];
            end
        end
    end

`ifdef CROP_STREAM_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Frame latency: cleared on accepted start, counts STREAM/DRAIN cycles, saturates.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (active && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_crop_stream_ctrl.sv
// Randomized scoreboard bench for crop_stream_ctrl: expected core beats and results are queued
// from frame geometry, a negedge monitor pops and compares whatever the DUT presents.
module tb_crop_stream_ctrl;
    localparam int FP = 16;
    localparam int NO = 5;
    localparam int ROWS = 100;
    localparam int COLS = 160;
    localparam int WIN = 48;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [6:0]        cfg_y1 = '0;
    logic [7:0]        cfg_x1 = '0;
    logic              cfg_err, busy;
    logic [FP-1:0]     pix_TDATA = '0;
    logic              pix_TVALID = 1'b0;
    logic              pix_TREADY;
    logic [FP-1:0]     core_in_TDATA;
    logic              core_in_TVALID;
    logic              core_in_TREADY = 1'b0;
    logic              core_ap_start;
    logic              core_ap_ready = 1'b0;
    logic              core_ap_done = 1'b0;
    logic [NO*FP-1:0]  core_out_TDATA = '0;
    logic [NO-1:0]     core_out_TVALID = '0;
    logic [NO-1:0]     core_out_TREADY;
    logic [NO*FP-1:0]  result_data;
    logic              result_valid;
    logic              result_ack = 1'b0;
    logic [31:0]       perf_cycles;

    crop_stream_ctrl dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start), .cfg_y1(cfg_y1),
        .cfg_x1(cfg_x1), .cfg_err(cfg_err), .busy(busy), .pix_TDATA(pix_TDATA),
        .pix_TVALID(pix_TVALID), .pix_TREADY(pix_TREADY), .core_in_TDATA(core_in_TDATA),
        .core_in_TVALID(core_in_TVALID), .core_in_TREADY(core_in_TREADY),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done), .core_out_TDATA(core_out_TDATA),
        .core_out_TVALID(core_out_TVALID), .core_out_TREADY(core_out_TREADY),
        .result_data(result_data), .result_valid(result_valid), .result_ack(result_ack),
        .perf_cycles(perf_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad = 0;
    bit stall_mode = 1'b0;

    logic [FP-1:0]    beat_q[$];
    logic [FP-1:0]    seen_q[$];
    logic [NO*FP-1:0] res_q[$];
    int pix_cnt = 0, disc_cnt = 0, aphs_cnt = 0, err_cnt = 0;
    bit prev_busy = 1'b0, prev_aphs = 1'b0, res_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [NO*FP-1:0] act,
                             input logic [NO*FP-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core side: ready stalls and start acknowledge, updated just after each edge.
    always @(posedge ap_clk) begin
        #1;
        core_in_TREADY = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        core_ap_ready  = core_ap_start && (!stall_mode || 1'($urandom_range(0, 1)));
    end

    // Monitor: compares every presented beat/result against the scoreboard queues.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (core_in_TVALID && core_in_TREADY) begin
                seen_q.push_back(core_in_TDATA);
                if (beat_q.size() == 0) check("beat_unexpected", int'(core_in_TDATA), -1);
                else check("core_in_beat", int'(core_in_TDATA), int'(beat_q.pop_front()));
            end
            if (pix_TVALID && pix_TREADY) begin
                pix_cnt++;
                if (!core_in_TVALID) disc_cnt++;
            end
            if (busy && !prev_busy) check("ap_start_first_cycle", int'(core_ap_start), 1);
            if (prev_aphs) check("ap_start_drop", int'(core_ap_start), 0);
            prev_aphs = core_ap_start && core_ap_ready;
            if (prev_aphs) aphs_cnt++;
            prev_busy = busy;
            if (cfg_err) err_cnt++;
            if (result_valid && !res_seen) begin
                res_seen = 1'b1;
                if (res_q.size() == 0) check_res("result_unexpected", result_data, 'x);
                else check_res("result_data", result_data, res_q.pop_front());
            end
            if (!result_valid) res_seen = 1'b0;
        end else begin
            prev_busy = 1'b0;
            prev_aphs = 1'b0;
        end
    end

    task automatic run_frame(input int y1, input int x1, input bit stall, input int abort_at,
                             input int dup_ch, input int hold, input bit inject,
                             input bit fixed_vals, input bit perf_chk);
        int beat_base, disc_base, aphs_base, err_base, p, guard, done_at, extra;
        bit hs, ok;
        logic [NO*FP-1:0] vals;
        logic [NO-1:0] dlv, now_hs;
        stall_mode = stall;
        beat_base = seen_q.size();
        disc_base = disc_cnt;
        aphs_base = aphs_cnt;
        err_base  = err_cnt;
        for (int r = y1; r < y1 + WIN; r++)
            for (int c = x1; c < x1 + WIN; c++) beat_q.push_back(16'(r * COLS + c));

        @(posedge ap_clk); #1;
        cfg_y1 = 7'(y1); cfg_x1 = 8'(x1); cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;

        p = 0; guard = 0;
        while (p < ROWS * COLS) begin
            if (abort_at >= 0 && p == abort_at) break;
            pix_TDATA  = 16'(p);
            pix_TVALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_start  = inject && (p == 100);
            if (cfg_start) begin cfg_y1 = 7'd99; cfg_x1 = 8'd0; end
            @(negedge ap_clk); hs = pix_TVALID && pix_TREADY;
            @(posedge ap_clk); #1;
            if (hs) p++;
            guard++;
            if (guard > 60000) begin
                check("frame_timeout", p, ROWS * COLS);
                break;
            end
        end
        cfg_start = 1'b0;

        if (abort_at >= 0) begin
            pix_TVALID = 1'b1;
            ap_rst_n = 1'b0;
            @(negedge ap_clk);
            check("rst_busy", int'(busy), 0);
            check("rst_pix_ready", int'(pix_TREADY), 0);
            check("rst_core_in_valid", int'(core_in_TVALID), 0);
            check("rst_core_out_ready", int'(core_out_TREADY), 0);
            check("rst_ap_start", int'(core_ap_start), 0);
            check("rst_result_valid", int'(result_valid), 0);
            check("rst_perf", int'(perf_cycles), 0);
            @(posedge ap_clk); #1;
            pix_TVALID = 1'b0;
            ap_rst_n = 1'b1;
            beat_q.delete();
            return;
        end
        pix_TVALID = 1'b0;
        check("inject_ignored_err", err_cnt - err_base, 0);

        // Core finishes: done plus one beat per channel, optional extra beat on dup_ch.
        if (fixed_vals) vals = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        else for (int k = 0; k < NO; k++) vals[k*FP +: FP] = 16'($urandom);
        res_q.push_back(vals);
        repeat (2) begin @(posedge ap_clk); #1; end
        done_at = (dup_ch >= 0) ? 3 : 0;
        dlv = '0; extra = 0;
        for (int cyc = 0; cyc < 500 && (dlv != '1 || extra < 5); cyc++) begin
            core_ap_done = (cyc == done_at);
            for (int k = 0; k < NO; k++) begin
                core_out_TDATA[k*FP +: FP] = dlv[k] ? 16'h00EE : vals[k*FP +: FP];
                core_out_TVALID[k] = dlv[k] ? (k == dup_ch) :
                                     (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            end
            @(negedge ap_clk);
            now_hs = core_out_TVALID & core_out_TREADY;
            if (dup_ch >= 0 && dlv[dup_ch])
                check("second_beat_refused", int'(core_out_TREADY[dup_ch]), 0);
            dlv = dlv | now_hs;
            if (dlv == '1 && cyc >= done_at) extra++;
            @(posedge ap_clk); #1;
        end
        core_ap_done = 1'b0;
        core_out_TVALID = '0;

        for (int i = 0; i < 2000 && !result_valid; i++) @(negedge ap_clk);
        check("result_reached", int'(result_valid), 1);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge ap_clk);
            ok &= result_valid && (result_data === vals);
        end
        check("result_hold", int'(ok), 1);
`ifdef CROP_STREAM_CTRL_PERF_EN
        if (perf_chk) check("perf_cycles", int'(perf_cycles >= 32'd16002 && perf_cycles <= 32'd16004), 1);
`else
        if (perf_chk) check("perf_cycles", int'(perf_cycles), 0);
`endif
        @(posedge ap_clk); #1; result_ack = 1'b1;
        @(posedge ap_clk); #1; result_ack = 1'b0;
        @(negedge ap_clk);
        check("ack_result_valid", int'(result_valid), 0);
        check("ack_busy", int'(busy), 0);
        check("beats_left", beat_q.size(), 0);
        check("beat_count", seen_q.size() - beat_base, WIN * WIN);
        if (seen_q.size() > beat_base) begin
            check("first_beat", int'(seen_q[beat_base]), y1 * COLS + x1);
            check("last_beat", int'(seen_q[seen_q.size() - 1]), (y1 + WIN - 1) * COLS + x1 + WIN - 1);
        end
        check("discarded", disc_cnt - disc_base, ROWS * COLS - WIN * WIN);
        check("ap_start_handshakes", aphs_cnt - aphs_base, 1);
    endtask

    task automatic bad_origin(input int y1, input int x1);
        int err_base;
        bit idle;
        err_base = err_cnt;
        @(posedge ap_clk); #1;
        cfg_y1 = 7'(y1); cfg_x1 = 8'(x1); cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
        idle = 1'b1;
        repeat (4) begin @(negedge ap_clk); idle &= !busy; end
        check("cfg_err_pulses", err_cnt - err_base, 1);
        check("cfg_err_busy", int'(idle), 1);
    endtask

    initial begin
        repeat (3) @(negedge ap_clk);
        check("reset_busy", int'(busy), 0);
        check("reset_pix_ready", int'(pix_TREADY), 0);
        check("reset_core_in_valid", int'(core_in_TVALID), 0);
        check("reset_ap_start", int'(core_ap_start), 0);
        check("reset_core_out_ready", int'(core_out_TREADY), 0);
        check("reset_result_valid", int'(result_valid), 0);
        check_res("reset_result_data", result_data, '0);
        check("reset_perf", int'(perf_cycles), 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        run_frame(10, 10, 1'b0, -1, -1, 3, 1'b1, 1'b0, 1'b1);
        bad_origin(53, 0);
        bad_origin(0, 113);
        run_frame(52, 112, 1'b0, -1, 2, 20, 1'b0, 1'b1, 1'b0);
        run_frame(10, 10, 1'b0, 5000, -1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(10, 10, 1'b1, -1, -1, 2, 1'b0, 1'b0, 1'b0);
        check("total_cfg_err", err_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crop_stream_ctrl.md
Name: crop_stream_ctrl

Overview:
- Sequences one inference of the hls4ml `myproject` core per input frame.
- Consumes a full IN_ROWS x IN_COLS pixel stream (row-major, one FP_TOTAL-bit pixel per beat).
- Forwards only the OUT_ROWS x OUT_COLS crop window at a configured origin into the core's input stream, and discards all other pixels.
- Drives the core's ap_start / ap_done protocol, captures one beat from each of the NUM_OUT output channels, and presents them as a single result.

Parameters:
- FP_TOTAL, 16, pixel/result word width in bits
- IN_ROWS, 100, input frame rows
- IN_COLS, 160, input frame columns
- OUT_ROWS, 48, crop rows
- OUT_COLS, 48, crop columns
- NUM_OUT, 5, number of core output channels
- Y_W, $clog2(IN_ROWS), row index width
- X_W, $clog2(IN_COLS), column index width

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle request to process the next frame
- cfg_y1  in  Y_W  crop origin row, sampled on accepted cfg_start
- cfg_x1  in  X_W  crop origin column, sampled on accepted cfg_start
- cfg_err  out  1  one-cycle pulse: crop window out of bounds, start rejected
- busy  out  1  high in every state except IDLE
- pix_TDATA  in  FP_TOTAL  frame pixel
- pix_TVALID  in  1  pixel valid
- pix_TREADY  out  1  pixel accepted
- core_in_TDATA  out  FP_TOTAL  cropped pixel to core
- core_in_TVALID  out  1  cropped pixel valid
- core_in_TREADY  in  1  core ready
- core_ap_start  out  1  core start
- core_ap_ready  in  1  core accepted start
- core_ap_done  in  1  core finished
- core_out_TDATA  in  NUM_OUT*FP_TOTAL  packed core outputs, channel k at [k*FP_TOTAL +: FP_TOTAL]
- core_out_TVALID  in  NUM_OUT  per-channel valid
- core_out_TREADY  out  NUM_OUT  per-channel ready
- result_data  out  NUM_OUT*FP_TOTAL  captured outputs
- result_valid  out  1  result held until acknowledged
- result_ack  in  1  consumer acknowledges result
- perf_cycles  out  32  latency counter (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; row/col counters, captured flags, done_seen, result_data, perf_cycles = 0. All outputs 0. Reset mid-operation aborts immediately; no partial result survives.
- IDLE -> STREAM on cfg_start when cfg_y1+OUT_ROWS<=IN_ROWS and cfg_x1+OUT_COLS<=IN_COLS. Origin is latched at that edge.
- Out-of-bounds origin: cfg_err pulses one cycle, state stays IDLE. cfg_start outside IDLE is ignored.
- core_ap_start rises in the first STREAM cycle and holds until core_ap_ready is sampled high. It deasserts the cycle after.
- STREAM, pixel path: in_win = (row in [y1, y1+OUT_ROWS-1]) and (col in [x1, x1+OUT_COLS-1]).
  - core_in_TDATA = pix_TDATA.
  - core_in_TVALID = pix_TVALID & in_win.
  - pix_TREADY = in_win ? core_in_TREADY : 1.
  - Purely combinational, zero latency, no buffering.
- Counters advance on each pix handshake. col wraps at IN_COLS-1 and increments row.
- Handshake on row IN_ROWS-1, col IN_COLS-1 -> DRAIN. The counters clear at the same edge.
- pix_TREADY is 0 outside STREAM.
- core_out_TREADY[k] = (STREAM or DRAIN) & ~captured[k]. Capture data and set captured[k] on the handshake. Only the first beat per channel is kept.
- done_seen is set on core_ap_done in STREAM or DRAIN, including the case where it coincides with a channel capture.
- DRAIN -> RESULT when all captured[] are set and done_seen is set. Evaluate the flags including same-cycle updates; transition occurs at the next edge.
- RESULT: result_valid=1 and result_data stable. On result_ack -> IDLE, with flags cleared and result_valid low the next cycle. result_ack outside RESULT is ignored.

Optional Feature:
- Macro: CROP_STREAM_CTRL_PERF_EN.
- Defined: perf_cycles clears on the accepted cfg_start and increments every cycle in STREAM and DRAIN, saturating at 2^32-1. It holds in RESULT and IDLE until the next accepted start.
- Undefined: perf_cycles is constant 0 and no counter logic is present.

Test Plan:
- Frame pixel = row*160+col, origin (10,10), all valids/readys high -> exactly 2304 core_in beats; first 1610, last 9177; 13696 pixels discarded; RESULT reached.
- Origin (52,112) -> accepted, first core beat 8432, last 15999. Origin (53,0) or (0,113) -> one cfg_err pulse, busy stays 0.
- Random pix_TVALID, core_in_TREADY, core_out_TVALID each 50% -> beat sequence identical to the no-stall run; no out-of-window pixel reaches core_in.
- Channels deliver values 1..5 with a second beat on channel 2 -> result_data = {5,4,3,2,1}, second beat not accepted; result_valid holds 20 cycles until result_ack, then IDLE.
- ap_rst_n low at pixel 5000 -> next cycle busy=0, all TREADY/TVALID=0, counters 0; the following frame at origin (10,10) passes the first test.
- With CROP_STREAM_CTRL_PERF_EN defined, no stalls, core_ap_done and outputs 3 cycles after the last pixel -> perf_cycles = 16003 (±1 per documented edge). Without the macro -> perf_cycles = 0.
